// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display
//   Sequential double-dabble converter: accepts one unsigned binary value per
//   start/ready handshake, shifts it through a BCD scratch register one bit per
//   cycle, and publishes the packed BCD result (digit 0 in [3:0]) together with an
//   overflow flag. The published result only changes on the cycle done is raised,
//   so a downstream 7-segment scan driver never sees a partially converted value.
//   Values above 10^DIGITS-1 skip the conversion and publish all-'E' digits.

module bin_to_bcd_display #(
    parameter int BIN_W  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
    function automatic logic [63:0] max_decimal(input int digits);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    // Double-dabble digit correction: every digit >= 5 gets +3 so the following
    // left shift carries correctly into the next decimal digit. Digits stay <= 9
    // before correction, so the 4-bit add never overflows into a neighbour.
    function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic [3:0]       dig;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            dig = v[4*d +: 4];
            if (dig >= 4'd5) begin
                r[4*d +: 4] = dig + 4'd3;
            end else begin
                r[4*d +: 4] = dig;
            end
        end
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = max_decimal(DIGITS);

    state_t             state_r;
    logic               ready_r;
    logic               done_r;
    logic               overflow_r;
    logic [BCD_W-1:0]   bcd_out_r;
    logic [BIN_W-1:0]   bin_r;
    logic [BCD_W-1:0]   scratch_r;
    logic [CNT_W-1:0]   count_r;

    logic [BCD_W-1:0]   scratch_adj_s;
    logic [BCD_W-1:0]   scratch_next_s;
    logic [63:0]        bin_ext_s;
    logic               too_big_s;
    logic               last_shift_s;

    // Combinational add-3 correction, next shifted scratch value and range test.
    always_comb begin
        scratch_adj_s  = add3_digits(scratch_r);
        scratch_next_s = {scratch_adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
        bin_ext_s      = 64'(bin);
        too_big_s      = (bin_ext_s > MAX_VAL);
        last_shift_s   = (count_r == CNT_W'(BIN_W - 1));
    end

    // Conversion FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
            bcd_out_r  <= '0;
            bin_r      <= '0;
            scratch_r  <= '0;
            count_r    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (too_big_s) begin
                            // Out of range: publish the error pattern right away.
                            bcd_out_r  <= {DIGITS{4'hE}};
                            overflow_r <= 1'b1;
                            done_r     <= 1'b1;
                        end else begin
                            bin_r     <= bin;
                            scratch_r <= '0;
                            count_r   <= '0;
                            state_r   <= SHIFT;
                            ready_r   <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_next_s;
                    bin_r     <= {bin_r[BIN_W-2:0], 1'b0};
                    count_r   <= count_r + CNT_W'(1);
                    if (last_shift_s) begin
                        // Result and flag are only ever published together here.
                        bcd_out_r  <= scratch_next_s;
                        overflow_r <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= IDLE;
                        ready_r    <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_r;
    assign done     = done_r;
    assign overflow = overflow_r;
    assign bcd_out  = bcd_out_r;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Testbench for bin_to_bcd_display: directed vectors, queue-based scoreboard,
// independent monitor that checks every done pulse against the queue.

module tb_bin_to_bcd_display;

    localparam int BIN_W  = 32;
    localparam int DIGITS = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] bin;
    logic        ready;
    logic        done;
    logic        overflow;
    logic [31:0] bcd_out;

    typedef struct {
        logic [31:0] bcd;
        logic        ov;
        int          done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    logic done_prev = 1'b0;

    bin_to_bcd_display #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .ready    (ready),
        .done     (done),
        .overflow (overflow),
        .bcd_out  (bcd_out)
    );

    always #5 clk = ~clk;

    // Edge counter used to time done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            chk("done_width", 64'(done_prev), 64'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual bcd=%h ov=%b expected no done", bcd_out, overflow);
            end else begin
                e = sb_q.pop_front();
                chk("bcd_out",    64'(bcd_out), 64'(e.bcd));
                chk("overflow",   64'(overflow), 64'(e.ov));
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            end
        end
        done_prev <= done;
    end

    // Wait (bounded) for ready, then issue one start; push expectation if lat >= 0.
    task automatic issue(input logic [31:0] b, input logic [31:0] e_bcd,
                         input logic e_ov, input int lat);
        exp_t e;
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", 64'(ready), 64'd1);
        start = 1'b1;
        bin   = b;
        @(posedge clk); #1;
        start = 1'b0;
        if (lat >= 0) begin
            e.bcd      = e_bcd;
            e.ov       = e_ov;
            e.done_cyc = cyc + lat;
            sb_q.push_back(e);
        end
    endtask

    // Full conversion: checks ready-low duration and that the result holds afterwards.
    task automatic run(input logic [31:0] b, input logic [31:0] e_bcd, input logic e_ov);
        int lowcnt;
        issue(b, e_bcd, e_ov, e_ov ? 0 : 32);
        lowcnt = 0;
        forever begin
            @(negedge clk);
            if (ready === 1'b1 || lowcnt >= 100) break;
            lowcnt++;
        end
        chk("ready_low_cycles", 64'(lowcnt), e_ov ? 64'd0 : 64'd32);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("hold_bcd", 64'(bcd_out), 64'(e_bcd));
        chk("hold_ov",  64'(overflow), 64'(e_ov));
    endtask

    initial begin
        exp_t e;
        int w;
        reset = 1'b0;
        start = 1'b0;
        bin   = 32'd0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_ov",    64'(overflow), 64'd0);
        chk("rst_bcd",   64'(bcd_out), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        run(32'd0,         32'h00000000, 1'b0);
        run(32'd12345678,  32'h12345678, 1'b0);
        run(32'd99999999,  32'h99999999, 1'b0);
        run(32'd100000000, 32'hEEEEEEEE, 1'b1);
        run(32'd42,        32'h00000042, 1'b0);

        // start during busy must be ignored
        issue(32'd2468, 32'h00002468, 1'b0, 32);
        repeat (10) begin
            @(posedge clk); #1;
        end
        start = 1'b1;
        bin   = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("busy_ignored_bcd", 64'(bcd_out), 64'h2468);

        // start held high: back-to-back conversions, done every 33 cycles
        start = 1'b1;
        bin   = 32'd5;
        @(posedge clk); #1;
        e.bcd = 32'h5; e.ov = 1'b0; e.done_cyc = cyc + 32;
        sb_q.push_back(e);
        bin = 32'd6;
        repeat (33) begin
            @(posedge clk); #1;
        end
        e.bcd = 32'h6; e.ov = 1'b0; e.done_cyc = cyc + 32;
        sb_q.push_back(e);
        start = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("b2b_final_bcd", 64'(bcd_out), 64'h6);

        // reset during shift 16 aborts the conversion
        issue(32'd87654321, 32'h87654321, 1'b0, -1);
        repeat (16) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_done",  64'(done), 64'd0);
        chk("abort_bcd",   64'(bcd_out), 64'd0);
        chk("abort_ov",    64'(overflow), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("post_abort_bcd", 64'(bcd_out), 64'd0);
        run(32'd87654321, 32'h87654321, 1'b0);

        w = 0;
        while (sb_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
